// File: rtl/pwm_tick_gen_if.sv
// pwm_tick_gen_if: groups the PWM generator's control inputs and waveform
// outputs so they can be passed around as a single bundle.
//   tick         advance pulse from the upstream divider
//   en           run enable, level-sensitive
//   duty         requested high time in ticks (CW bits)
//   pwm_out      registered PWM waveform
//   period_start one-cycle pulse on each period wrap
//   cnt          current tick position inside the period
// master drives the controls and observes the outputs; slave is the generator.
interface pwm_tick_gen_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          en;
  logic [CW-1:0] duty;
  logic          pwm_out;
  logic          period_start;
  logic [CW-1:0] cnt;

  modport master (
    output tick, en, duty,
    input  pwm_out, period_start, cnt
  );

  modport slave (
    input  tick, en, duty,
    output pwm_out, period_start, cnt
  );
endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: PWM waveform whose time base advances only on the divider
// tick. The duty request is double-buffered in a shadow register that is
// reloaded only while idle or at a period wrap, so a duty change never
// produces a runt or stretched pulse.
// Ports:
//   sys_clk    system clock, the only clock
//   sys_rst_n  asynchronous active-low reset
//   bus        pwm_tick_gen_if.slave: tick/en/duty in, pwm_out/period_start/cnt out
module pwm_tick_gen #(
  parameter int PERIOD = 10,
  parameter int CW     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  pwm_tick_gen_if.slave    bus
);

  localparam logic [CW-1:0] PER_C  = CW'(PERIOD);
  localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_sh_q, duty_sh_d;
  logic          pwm_q, pwm_d;
  logic          ps_q, ps_d;
  logic [CW-1:0] dsat;
  logic          adv;

  // Requests above the period would just mean "always high"; clamp so the
  // shadow never holds a value the counter cannot reach.
  assign dsat = (bus.duty > PER_C) ? PER_C : bus.duty;
  assign adv  = bus.en & bus.tick;

  always_comb begin
    cnt_d     = cnt_q;
    duty_sh_d = duty_sh_q;
    ps_d      = 1'b0;
    // Uses the pre-edge enable, so dropping en clears pwm on the same edge
    // that clears the counter.
    pwm_d     = bus.en & (cnt_q < duty_sh_q);
    if (!bus.en) begin
      // Idle keeps the shadow tracking the request so the first period after
      // enable already uses the current duty.
      cnt_d     = '0;
      duty_sh_d = dsat;
    end else if (adv) begin
      if (cnt_q == LAST_C) begin
        cnt_d     = '0;
        duty_sh_d = dsat;
        ps_d      = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end

  assign bus.cnt          = cnt_q;
  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_tick_gen.sv
module tb_pwm_tick_gen;
  localparam int P  = 4;
  localparam int CW = 8;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  pwm_tick_gen_if #(.CW(CW)) bus ();

  pwm_tick_gen #(.PERIOD(P), .CW(CW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: counts ticks accepted since the run began; position is
  // that count modulo the period, and every multiple of the period is a wrap
  // that reloads the shadow duty.
  int m_ticks, m_sh, m_cnt;
  bit m_pwm, m_ps;

  task automatic model_reset();
    m_ticks = 0; m_sh = 0; m_cnt = 0; m_pwm = 0; m_ps = 0;
  endtask

  // Drive one cycle of inputs at the negedge, advance the model at the
  // posedge, return 1 time unit after the edge for sampling.
  task automatic step(input bit t, input bit e, input int d);
    int dsat;
    @(negedge sys_clk);
    bus.tick = t; bus.en = e; bus.duty = CW'(d);
    @(posedge sys_clk);
    dsat  = (d > P) ? P : d;
    m_pwm = e && (m_cnt < m_sh);
    m_ps  = 0;
    if (!e) begin
      m_ticks = 0;
      m_sh    = dsat;
    end else if (t) begin
      m_ticks++;
      if (m_ticks % P == 0) begin
        m_sh = dsat;
        m_ps = 1;
      end
    end
    m_cnt = m_ticks % P;
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bus.tick = 0; bus.en = 0; bus.duty = '0;
    model_reset();
    #12;
    checks++; if (bus.cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.cnt); end
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", bus.pwm_out); end
    checks++; if (bus.period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want 0", bus.period_start); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(0, 0, 0);
    checks++; if (bus.period_start !== 1'b0) begin errors++; $display("FAIL reset_release_ps got %b want 0", bus.period_start); end
  endtask

  task automatic test_steady();
    int highs = 0, pulses = 0;
    step(0, 0, 1); step(0, 0, 1);
    for (int i = 0; i < 72; i++) begin
      step(i % 6 == 5, 1, 1);
      if (bus.pwm_out === 1'b1) highs++;
      if (bus.period_start === 1'b1) begin
        pulses++;
        checks++;
        if (i % 24 != 23 || bus.cnt !== '0) begin
          errors++; $display("FAIL steady_ps_pos got cyc %0d cnt %0d want cyc%%24=23 cnt 0", i, bus.cnt);
        end
      end
      checks++;
      if (bus.cnt !== CW'(m_cnt) || bus.pwm_out !== m_pwm) begin
        errors++; $display("FAIL steady_model cyc %0d got cnt %0d pwm %b want cnt %0d pwm %b", i, bus.cnt, bus.pwm_out, m_cnt, m_pwm);
      end
    end
    checks++; if (highs != 18) begin errors++; $display("FAIL steady_high got %0d want 18", highs); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL steady_pulses got %0d want 3", pulses); end
    step(0, 0, 0);
  endtask

  task automatic test_duty_extremes();
    int dv [3] = '{0, 4, 9};
    int want [3] = '{0, 24, 24};
    for (int k = 0; k < 3; k++) begin
      int highs = 0;
      step(0, 0, dv[k]); step(0, 0, dv[k]);
      for (int i = 0; i < 24; i++) begin
        step(i % 6 == 5, 1, dv[k]);
        if (bus.pwm_out === 1'b1) highs++;
      end
      checks++;
      if (highs != want[k]) begin errors++; $display("FAIL extreme_duty%0d got %0d highs want %0d", dv[k], highs, want[k]); end
      step(0, 0, 0);
    end
  endtask

  task automatic test_mid_duty();
    int h1 = 0, h2 = 0;
    step(0, 0, 1);
    for (int i = 0; i < 48; i++) begin
      step(i % 6 == 5, 1, (i < 8) ? 1 : 3);
      if (i < 24) h1 += int'(bus.pwm_out === 1'b1);
      else        h2 += int'(bus.pwm_out === 1'b1);
      if (i == 23) begin
        checks++;
        if (bus.period_start !== 1'b1 || bus.pwm_out !== 1'b0) begin
          errors++; $display("FAIL mid_wrap got ps %b pwm %b want ps 1 pwm 0", bus.period_start, bus.pwm_out);
        end
      end
      if (i == 24) begin
        checks++;
        if (bus.pwm_out !== 1'b1) begin errors++; $display("FAIL mid_newperiod_pwm got %b want 1", bus.pwm_out); end
      end
    end
    checks++; if (h1 != 6)  begin errors++; $display("FAIL mid_old_period got %0d highs want 6", h1); end
    checks++; if (h2 != 18) begin errors++; $display("FAIL mid_new_period got %0d highs want 18", h2); end
    step(0, 0, 0);
  endtask

  task automatic test_enable_drop();
    int highs = 0, pulses = 0;
    step(0, 0, 2);
    for (int i = 0; i < 13; i++) step(i % 6 == 5, 1, 2);
    checks++; if (bus.cnt !== CW'(2)) begin errors++; $display("FAIL drop_precnt got %0d want 2", bus.cnt); end
    step(0, 0, 2);
    checks++; if (bus.cnt !== '0) begin errors++; $display("FAIL drop_cnt got %0d want 0", bus.cnt); end
    step(1, 0, 2);
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL drop_pwm got %b want 0", bus.pwm_out); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 2);
      checks++;
      if (bus.cnt !== '0 || bus.pwm_out !== 1'b0) begin
        errors++; $display("FAIL drop_tick_ignored got cnt %0d pwm %b want 0 0", bus.cnt, bus.pwm_out);
      end
    end
    for (int i = 0; i < 23; i++) begin
      step(i % 6 == 5, 1, 2);
      highs  += int'(bus.pwm_out === 1'b1);
      pulses += int'(bus.period_start === 1'b1);
    end
    checks++; if (highs != 12) begin errors++; $display("FAIL reen_high got %0d want 12", highs); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL reen_ps got %0d want 0", pulses); end
    step(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    step(0, 0, 2);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 2);
      checks++;
      if (bus.cnt !== CW'((i + 1) % P) || bus.pwm_out !== ((i % P) < 2)) begin
        errors++; $display("FAIL b2b cyc %0d got cnt %0d pwm %b want cnt %0d pwm %b", i, bus.cnt, bus.pwm_out, (i + 1) % P, (i % P) < 2);
      end
    end
    step(0, 0, 0);
  endtask

  task automatic test_async_reset();
    step(0, 0, 4);
    for (int i = 0; i < 3; i++) step(1, 1, 4);
    checks++;
    if (bus.cnt !== CW'(3) || bus.pwm_out !== 1'b1) begin
      errors++; $display("FAIL arst_pre got cnt %0d pwm %b want 3 1", bus.cnt, bus.pwm_out);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.cnt !== '0 || bus.pwm_out !== 1'b0 || bus.period_start !== 1'b0) begin
      errors++; $display("FAIL arst_immediate got cnt %0d pwm %b ps %b want 0 0 0", bus.cnt, bus.pwm_out, bus.period_start);
    end
    #3 sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(i > 0, i > 0, 4);
      checks++;
      if (bus.period_start !== m_ps || bus.cnt !== CW'(m_cnt)) begin
        errors++; $display("FAIL arst_after cyc %0d got ps %b cnt %0d want ps %b cnt %0d", i, bus.period_start, bus.cnt, m_ps, m_cnt);
      end
    end
    step(0, 0, 0);
  endtask

  task automatic test_random();
    int d = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 12));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) != 0, d);
      checks++;
      if (bus.cnt !== CW'(m_cnt) || bus.pwm_out !== m_pwm || bus.period_start !== m_ps) begin
        errors++; $display("FAIL random cyc %0d got cnt %0d pwm %b ps %b want cnt %0d pwm %b ps %b",
                           i, bus.cnt, bus.pwm_out, bus.period_start, m_cnt, m_pwm, m_ps);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_extremes();
    test_mid_duty();
    test_enable_drop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
